// File: rtl/qif_pkg.sv
// Shared types, limits and helpers for the QIF spike decoder.
// Holds the ISI FSM state type, the ISI ceiling and the sat8 clamp.
package qif_pkg;

  typedef enum logic {
    IDLE,
    COUNT
  } isi_state_t;

  localparam int ISI_MAX = 255;
  localparam int DEF_DECAY_SHIFT = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  function automatic logic signed [7:0] sat8(
    input logic signed [9:0] v
  );
    if (v > 10'sd127) begin
      return 8'sh7f;
    end else if (v < -10'sd128) begin
      return 8'sh80;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/isi_fifo.sv
// ISI result buffer: push side with full flag, valid/ready pop side.
// Ports: clk, rst_n, push, din, full, dout (0 when empty), valid, ready.
module isi_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout,
  output logic         valid,
  input  logic         ready
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         pop;
  logic         wr;

  assign valid = (wp != rp);
  // Extra pointer bit tells a wrapped writer (full) from equal (empty).
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = valid & ready;
  // A pop in the same cycle frees the slot a full push needs.
  assign wr    = push & (~full | pop);
  assign dout  = valid ? mem[rp[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wp[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/qif_spike_decoder.sv
// Decodes a spike train into a decaying synaptic current and a FIFO of
// inter-spike intervals. Ports: clk, rst_n, ena, spike_in, weight,
// clr_ovf, isi_ready in; i_syn, isi, isi_valid, overflow out.
module qif_spike_decoder
  import qif_pkg::*;
#(
  parameter int DECAY_SHIFT = DEF_DECAY_SHIFT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spike_in,
  input  logic signed [7:0] weight,
  input  logic              clr_ovf,
  input  logic              isi_ready,
  output logic signed [7:0] i_syn,
  output logic [7:0]        isi,
  output logic              isi_valid,
  output logic              overflow
);

  logic              spike_q;
  logic              evt;
  logic signed [9:0] cur_x;
  logic signed [9:0] add_x;
  logic signed [9:0] nxt;
  isi_state_t        state;
  logic [7:0]        cnt;
  logic              push;
  logic              full;
  logic              pop;
  logic              drop;

  // Rising edge only, and only while enabled.
  assign evt = spike_in & ~spike_q & ena;

  assign cur_x = {{2{i_syn[7]}}, i_syn};
  assign add_x = evt ? {{2{weight[7]}}, weight} : 10'sd0;
  assign nxt   = cur_x - (cur_x >>> DECAY_SHIFT) + add_x;

  assign push = evt & (state == COUNT);
  assign pop  = isi_valid & isi_ready;
  assign drop = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_syn <= '0;
    end else if (ena) begin
      i_syn <= sat8(nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (ena) begin
      unique case (state)
        IDLE: begin
          if (evt) begin
            state <= COUNT;
            cnt   <= 8'd1;
          end
        end
        COUNT: begin
          if (evt) begin
            cnt <= 8'd1;
          end else if (cnt != 8'(ISI_MAX)) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A drop wins over a simultaneous clear so no loss goes unreported.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  isi_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (cnt),
    .full  (full),
    .dout  (isi),
    .valid (isi_valid),
    .ready (isi_ready)
  );

endmodule

// File: tb/tb_qif_spike_decoder.sv
// Scoreboard bench for qif_spike_decoder: directed spike patterns push
// expected ISIs into a queue, a monitor compares each popped result.
module tb_qif_spike_decoder;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic              spike_in = 1'b0;
  logic signed [7:0] weight = '0;
  logic              clr_ovf = 1'b0;
  logic              isi_ready = 1'b0;
  logic signed [7:0] i_syn;
  logic [7:0]        isi;
  logic              isi_valid;
  logic              overflow;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  qif_spike_decoder #(
    .DECAY_SHIFT (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .spike_in  (spike_in),
    .weight    (weight),
    .clr_ovf   (clr_ovf),
    .isi_ready (isi_ready),
    .i_syn     (i_syn),
    .isi       (isi),
    .isi_valid (isi_valid),
    .overflow  (overflow)
  );

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse();
    spike_in = 1'b1;
    cyc();
    spike_in = 1'b0;
  endtask

  task automatic do_reset();
    isi_ready = 1'b0;
    clr_ovf = 1'b0;
    ena = 1'b1;
    rst_n = 1'b0;
    spike_in = 1'b1;
    cyc();
    spike_in = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_q.delete();
    chk("rst_isyn", int'(i_syn), 0);
    chk("rst_isi", int'(isi), 0);
    chk("rst_valid", int'(isi_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    isi_ready = 1'b1;
    while (exp_q.size() > 0 && k < 50) begin
      cyc();
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", int'(isi_valid), 0);
    chk("drain_isi", int'(isi), 0);
  endtask

  // Monitor: every handshake must match the oldest expected ISI.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (isi_valid === 1'b1 && isi_ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL isi_extra: got %0d want none", isi);
        end else begin
          e = exp_q.pop_front();
          if (int'(isi) != e) begin
            bad++;
            $display("FAIL isi_val: got %0d want %0d", isi, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int hold_exp[5];
    hold_exp = '{100, 75, 57, 43, 33};

    // Reset, then first spike must not push.
    do_reset();
    weight = 8'sd20;
    pulse();
    chk("first_isyn", int'(i_syn), 20);
    idle(5);
    chk("first_nopush", int'(isi_valid), 0);

    // Decay of a single +40 pulse.
    do_reset();
    weight = 8'sd40;
    pulse();
    chk("dec0", int'(i_syn), 40);
    cyc();
    chk("dec1", int'(i_syn), 30);
    cyc();
    chk("dec2", int'(i_syn), 23);
    cyc();
    chk("dec3", int'(i_syn), 18);
    cyc();
    chk("dec4", int'(i_syn), 14);

    // Most negative weight.
    do_reset();
    weight = 8'sh80;
    pulse();
    chk("neg0", int'(i_syn), -128);
    cyc();
    chk("neg1", int'(i_syn), -96);

    // Saturation on a second pulse two cycles later.
    do_reset();
    isi_ready = 1'b1;
    weight = 8'sd100;
    pulse();
    chk("sat0", int'(i_syn), 100);
    cyc();
    chk("sat1", int'(i_syn), 75);
    exp_q.push_back(2);
    pulse();
    chk("sat2", int'(i_syn), 127);
    drain();

    // A held-high level is one event.
    do_reset();
    isi_ready = 1'b1;
    weight = 8'sd100;
    spike_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold", int'(i_syn), hold_exp[i]);
    end
    spike_in = 1'b0;
    idle(2);
    exp_q.push_back(7);
    pulse();
    chk("hold_next", int'(i_syn), 115);
    drain();

    // ISI 7, then a long gap saturating at 255.
    do_reset();
    isi_ready = 1'b1;
    weight = 8'sd1;
    pulse();
    idle(6);
    exp_q.push_back(7);
    pulse();
    idle(299);
    exp_q.push_back(255);
    pulse();
    drain();

    // Enable low freezes current and count; lost edge while disabled.
    do_reset();
    isi_ready = 1'b1;
    weight = 8'sd53;
    pulse();
    idle(2);
    chk("ena_pre", int'(i_syn), 30);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) spike_in = 1'b1;
      if (i == 5) spike_in = 1'b0;
      cyc();
    end
    chk("ena_hold", int'(i_syn), 30);
    chk("ena_nopush", int'(isi_valid), 0);
    ena = 1'b1;
    idle(4);
    chk("ena_dec", int'(i_syn), 11);
    exp_q.push_back(7);
    pulse();
    chk("ena_evt", int'(i_syn), 62);
    drain();

    // Overflow: six intervals of 5 into a depth-4 buffer.
    do_reset();
    weight = 8'sd1;
    pulse();
    repeat (6) begin
      idle(4);
      pulse();
    end
    repeat (4) exp_q.push_back(5);
    chk("ovf_valid", int'(isi_valid), 1);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_head", int'(isi), 5);
    idle(4);
    clr_ovf = 1'b1;
    pulse();
    clr_ovf = 1'b0;
    chk("ovf_clr_drop", int'(overflow), 1);
    isi_ready = 1'b1;
    idle(4);
    chk("ovf_empty", int'(isi_valid), 0);
    chk("ovf_left", exp_q.size(), 0);
    chk("ovf_still", int'(overflow), 1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("ovf_clr", int'(overflow), 0);

    // Full plus simultaneous push and pop is accepted.
    do_reset();
    weight = 8'sd1;
    pulse();
    repeat (4) begin
      idle(2);
      pulse();
    end
    repeat (4) exp_q.push_back(3);
    chk("full_ovf", int'(overflow), 0);
    idle(2);
    isi_ready = 1'b1;
    exp_q.push_back(3);
    pulse();
    chk("full_pp_ovf", int'(overflow), 0);
    drain();

    // Reset mid-operation discards buffered results.
    isi_ready = 1'b0;
    pulse();
    idle(2);
    pulse();
    chk("mid_valid", int'(isi_valid), 1);
    do_reset();
    pulse();
    idle(3);
    chk("mid_nopush", int'(isi_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
